// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: interrupt dispatch states, register file layout,
// register-pair selector and interrupt vector helpers.
package gb_cpu_common_pkg;

  localparam int         INT_NUM      = 5;
  localparam logic [7:0] INT_VEC_BASE = 8'h40;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    DEC_SP  = 3'd2,
    PUSH_HI = 3'd3,
    PUSH_LO = 3'd4,
    JUMP    = 3'd5
  } int_dispatch_state_t;

  // SP is encoded as zero so an idle write port naturally points at SP.
  typedef enum logic [2:0] {
    R16_SP = 3'd0,
    R16_BC = 3'd1,
    R16_DE = 3'd2,
    R16_HL = 3'd3,
    R16_PC = 3'd4
  } regfile_r16_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] f;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [7:0] e;
    logic [7:0] h;
    logic [7:0] l;
    logic [7:0] sp_hi;
    logic [7:0] sp_lo;
    logic [7:0] pc_hi;
    logic [7:0] pc_lo;
  } regfile_t;

  // Restart address for interrupt source idx: 0x40, 0x48, ... 0x60.
  function automatic logic [7:0] int_vector(input logic [2:0] idx);
    return INT_VEC_BASE + {2'b00, idx, 3'b000};
  endfunction

endpackage

// File: rtl/gb_cpu_int_dispatch_if.sv
// Memory write bus driven by the interrupt dispatcher during the PC push.
interface gb_cpu_int_dispatch_if;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;
  logic        bus_wr;

  modport master (output bus_addr, output bus_data, output bus_wr);
  modport slave  (input  bus_addr, input  bus_data, input  bus_wr);
endinterface

// File: rtl/gb_cpu_int_priority.sv
// Fixed-priority interrupt encoder: lowest set pending bit wins.
module gb_cpu_int_priority
  import gb_cpu_common_pkg::*;
(
  input  logic [INT_NUM-1:0] pending,
  output logic               valid,
  output logic [2:0]         index,
  output logic [INT_NUM-1:0] mask
);

  // Scan from the highest bit down so the lowest set bit is the last to win.
  always_comb begin
    valid = 1'b0;
    index = 3'd0;
    mask  = '0;
    for (int i = INT_NUM - 1; i >= 0; i--) begin
      if (pending[i]) begin
        valid   = 1'b1;
        index   = 3'(i);
        mask    = '0;
        mask[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gb_cpu_int_dispatch.sv
// Interrupt dispatch sequencer: waits for an enabled pending interrupt at an
// instruction boundary (or in HALT), then pushes PC onto the stack over five
// machine cycles and loads PC with the winning restart vector.
module gb_cpu_int_dispatch
  import gb_cpu_common_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  boundary,
  input  logic                  ime,
  input  logic                  halted,
  input  logic [INT_NUM-1:0]    int_enable,
  input  logic [INT_NUM-1:0]    int_flag,
  input  regfile_t              registers,
  output logic                  dispatch_active,
  output logic                  wake,
  output regfile_r16_t          idu_req,
  output logic [15:0]           idu_data,
  output logic                  idu_wren,
  output logic                  write_interrupt_vector,
  output logic [7:0]            interrupt_vector,
  gb_cpu_int_dispatch_if.master bus,
  output logic [INT_NUM-1:0]    if_ack,
  output logic                  ime_clear
);

  int_dispatch_state_t state, state_next;

  logic [INT_NUM-1:0] pending;
  logic               pend_valid;
  logic [2:0]         pend_index;
  logic [INT_NUM-1:0] pend_mask;
  logic [7:0]         vec_q;
  logic [INT_NUM-1:0] mask_q;
  logic [15:0]        sp;

  assign pending = int_enable & int_flag;
  assign sp      = {registers.sp_hi, registers.sp_lo};

  // Only SP and PC are consumed; the remaining registers are deliberately ignored.
  wire unused_regs = ^{registers.a, registers.f, registers.b, registers.c,
                       registers.d, registers.e, registers.h, registers.l};

  gb_cpu_int_priority u_priority (
    .pending (pending),
    .valid   (pend_valid),
    .index   (pend_index),
    .mask    (pend_mask)
  );

  // HALT exit is requested by any enabled pending interrupt, regardless of IME.
  assign wake            = reset & halted & (|pending);
  assign dispatch_active = (state != IDLE);

  // State register; reset forces IDLE immediately, even mid-sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Capture the winning vector after the high-byte push, since that write
  // may have landed on IE and cancelled the request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_q  <= 8'h00;
      mask_q <= '0;
    end else if (state == PUSH_LO) begin
      vec_q  <= pend_valid ? int_vector(pend_index) : 8'h00;
      mask_q <= pend_mask;
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    state_next             = state;
    idu_req                = R16_SP;
    idu_data               = 16'h0000;
    idu_wren               = 1'b0;
    write_interrupt_vector = 1'b0;
    interrupt_vector       = 8'h00;
    bus.bus_addr           = 16'h0000;
    bus.bus_data           = 8'h00;
    bus.bus_wr             = 1'b0;
    if_ack                 = '0;
    ime_clear              = 1'b0;
    case (state)
      IDLE: begin
        if (ime && (|pending) && (boundary || halted)) state_next = WAIT;
      end
      WAIT: begin
        ime_clear  = 1'b1;
        state_next = DEC_SP;
      end
      DEC_SP: begin
        idu_data   = sp - 16'd1;
        idu_wren   = 1'b1;
        state_next = PUSH_HI;
      end
      PUSH_HI: begin
        bus.bus_addr = sp;
        bus.bus_data = registers.pc_hi;
        bus.bus_wr   = 1'b1;
        idu_data     = sp - 16'd1;
        idu_wren     = 1'b1;
        state_next   = PUSH_LO;
      end
      PUSH_LO: begin
        bus.bus_addr = sp;
        bus.bus_data = registers.pc_lo;
        bus.bus_wr   = 1'b1;
        state_next   = JUMP;
      end
      JUMP: begin
        write_interrupt_vector = 1'b1;
        interrupt_vector       = vec_q;
        if_ack                 = mask_q;
        state_next             = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gb_cpu_int_dispatch.sv
// Scoreboard bench for gb_cpu_int_dispatch: stimulus queues expected bus
// writes and PC loads; a monitor process compares them as the DUT emits them.
module tb_gb_cpu_int_dispatch;
  import gb_cpu_common_pkg::*;

  typedef struct packed {logic [15:0] addr; logic [7:0] data;} wr_t;
  typedef struct packed {logic [7:0] vec; logic [4:0] mask;} jmp_t;

  logic         clk;
  logic         reset;
  logic         boundary;
  logic         halted;
  logic         dispatch_active, wake, idu_wren, write_interrupt_vector, ime_clear;
  regfile_r16_t idu_req;
  logic [15:0]  idu_data;
  logic [7:0]   interrupt_vector;
  logic [4:0]   if_ack;
  regfile_t     regs;

  // Register file / memory / IE / IF / IME model
  logic [15:0] sp_m = 16'h0000, pc_m = 16'h0000;
  logic [4:0]  ie_m = 5'h00, if_m = 5'h00;
  logic        ime_m = 1'b0;
  logic        ld = 1'b0;
  logic [15:0] ld_sp = 16'h0, ld_pc = 16'h0;
  logic [4:0]  ld_ie = 5'h0, ld_if = 5'h0;
  logic        ld_ime = 1'b0;

  wr_t  wr_q[$];
  jmp_t jmp_q[$];
  int   checks = 0;
  int   errors = 0;

  gb_cpu_int_dispatch_if bus ();

  gb_cpu_int_dispatch dut (
    .clk                    (clk),
    .reset                  (reset),
    .boundary               (boundary),
    .ime                    (ime_m),
    .halted                 (halted),
    .int_enable             (ie_m),
    .int_flag               (if_m),
    .registers              (regs),
    .dispatch_active        (dispatch_active),
    .wake                   (wake),
    .idu_req                (idu_req),
    .idu_data               (idu_data),
    .idu_wren               (idu_wren),
    .write_interrupt_vector (write_interrupt_vector),
    .interrupt_vector       (interrupt_vector),
    .bus                    (bus),
    .if_ack                 (if_ack),
    .ime_clear              (ime_clear)
  );

  assign regs = {64'h0, sp_m, pc_m};

  wire [61:0] all_outs = {dispatch_active, wake, idu_req, idu_data, idu_wren,
                          write_interrupt_vector, interrupt_vector, bus.bus_addr,
                          bus.bus_data, bus.bus_wr, if_ack, ime_clear};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // CPU-side model reacting to the dispatcher's writes
  always @(posedge clk) begin
    if (ld) begin
      sp_m <= ld_sp; pc_m <= ld_pc; ie_m <= ld_ie; if_m <= ld_if; ime_m <= ld_ime;
    end else begin
      if (idu_wren && idu_req == R16_SP) sp_m <= idu_data;
      if (write_interrupt_vector) pc_m <= {8'h00, interrupt_vector};
      if (bus.bus_wr && bus.bus_addr == 16'hFFFF) ie_m <= bus.bus_data[4:0];
      if (ime_clear) ime_m <= 1'b0;
      if_m <= if_m & ~if_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic monitor_loop();
    wr_t  w;
    jmp_t j;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.bus_wr) begin
          checks++;
          if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL bus_write got %h@%h want none", bus.bus_data, bus.bus_addr);
          end else begin
            w = wr_q.pop_front();
            if (bus.bus_addr !== w.addr || bus.bus_data !== w.data) begin
              errors++;
              $display("FAIL bus_write got %h@%h want %h@%h", bus.bus_data, bus.bus_addr, w.data, w.addr);
            end
          end
        end
        if (write_interrupt_vector) begin
          checks++;
          if (jmp_q.size() == 0) begin
            errors++;
            $display("FAIL jump got vec=%h ack=%b want none", interrupt_vector, if_ack);
          end else begin
            j = jmp_q.pop_front();
            if (interrupt_vector !== j.vec || if_ack !== j.mask) begin
              errors++;
              $display("FAIL jump got vec=%h ack=%b want vec=%h ack=%b", interrupt_vector, if_ack, j.vec, j.mask);
            end
          end
        end
        if (idu_wren) begin
          checks++;
          if (idu_req !== R16_SP || idu_data !== sp_m - 16'd1) begin
            errors++;
            $display("FAIL idu_write got %0d:%h want %0d:%h", idu_req, idu_data, R16_SP, sp_m - 16'd1);
          end
        end
      end
    end
  endtask

  task automatic load(input logic [15:0] s, input logic [15:0] p, input logic [4:0] e,
                      input logic [4:0] f, input logic m);
    @(negedge clk);
    ld_sp = s; ld_pc = p; ld_ie = e; ld_if = f; ld_ime = m; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Start (optionally via boundary pulse) and time one dispatch sequence.
  task automatic run_dispatch(input string name, input bit pulse);
    bit seen;
    int n;
    seen = 1'b0;
    if (pulse) boundary = 1'b1;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      boundary = 1'b0;
      if (dispatch_active) seen = 1'b1;
    end
    chk({name, "_start"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({name, "_ime_clear"}, 64'(ime_clear), 64'd1);
      n = 1;
      while (dispatch_active && n < 10) begin
        @(negedge clk);
        if (dispatch_active) begin
          n++;
          if (ime_clear) chk({name, "_ime_clear_extra"}, 64'(ime_clear), 64'd0);
        end
      end
      chk({name, "_cycles"}, 64'(n), 64'd5);
    end
  endtask

  initial begin
    reset = 1'b0; boundary = 1'b0; halted = 1'b0;
    fork
      monitor_loop();
    join_none
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'(all_outs), 64'd0);
    reset = 1'b1;

    // Basic dispatch of source 2
    load(16'hFFFE, 16'h0150, 5'h04, 5'h04, 1'b1);
    wr_q.push_back('{addr: 16'hFFFD, data: 8'h01});
    wr_q.push_back('{addr: 16'hFFFC, data: 8'h50});
    jmp_q.push_back('{vec: 8'h50, mask: 5'b00100});
    run_dispatch("basic", 1'b1);
    chk("basic_sp", 64'(sp_m), 64'hFFFC);
    chk("basic_pc", 64'(pc_m), 64'h0050);
    chk("basic_if", 64'(if_m), 64'h00);

    // Priority: all pending -> source 0; then only source 4
    load(16'hD000, 16'h1234, 5'h1F, 5'h1F, 1'b1);
    wr_q.push_back('{addr: 16'hCFFF, data: 8'h12});
    wr_q.push_back('{addr: 16'hCFFE, data: 8'h34});
    jmp_q.push_back('{vec: 8'h40, mask: 5'b00001});
    run_dispatch("prio_all", 1'b1);
    chk("prio_all_pc", 64'(pc_m), 64'h0040);
    load(16'hCFFE, 16'h0040, 5'h1F, 5'h10, 1'b1);
    wr_q.push_back('{addr: 16'hCFFD, data: 8'h00});
    wr_q.push_back('{addr: 16'hCFFC, data: 8'h40});
    jmp_q.push_back('{vec: 8'h60, mask: 5'b10000});
    run_dispatch("prio_hi", 1'b1);
    chk("prio_hi_pc", 64'(pc_m), 64'h0060);
    chk("prio_hi_sp", 64'(sp_m), 64'hCFFC);

    // High-byte push lands on IE and cancels the request; SP wraps
    load(16'h0000, 16'h0234, 5'h01, 5'h01, 1'b1);
    wr_q.push_back('{addr: 16'hFFFF, data: 8'h02});
    wr_q.push_back('{addr: 16'hFFFE, data: 8'h34});
    jmp_q.push_back('{vec: 8'h00, mask: 5'b00000});
    run_dispatch("cancel", 1'b1);
    chk("cancel_pc", 64'(pc_m), 64'h0000);
    chk("cancel_sp", 64'(sp_m), 64'hFFFE);
    chk("cancel_ie", 64'(ie_m), 64'h02);

    // HALT wake without IME, then dispatch once IME is set
    halted = 1'b1;
    load(16'hC000, 16'h0300, 5'h02, 5'h02, 1'b0);
    chk("halt_wake", 64'(wake), 64'd1);
    repeat (3) @(negedge clk);
    chk("halt_no_dispatch", 64'(dispatch_active), 64'd0);
    load(16'hC000, 16'h0300, 5'h02, 5'h02, 1'b1);
    wr_q.push_back('{addr: 16'hBFFF, data: 8'h03});
    wr_q.push_back('{addr: 16'hBFFE, data: 8'h00});
    jmp_q.push_back('{vec: 8'h48, mask: 5'b00010});
    run_dispatch("halt", 1'b0);
    chk("halt_pc", 64'(pc_m), 64'h0048);
    chk("halt_wake_after", 64'(wake), 64'd0);
    halted = 1'b0;

    // Reset asserted during PUSH_HI, then a fresh dispatch
    load(16'hFFFE, 16'h0150, 5'h04, 5'h04, 1'b1);
    wr_q.push_back('{addr: 16'hFFFD, data: 8'h01});
    boundary = 1'b1;
    @(negedge clk);
    boundary = 1'b0;
    chk("rst_wait_active", 64'(dispatch_active), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("rst_push_hi_wr", 64'(bus.bus_wr), 64'd1);
    #2 reset = 1'b0;
    #1 chk("rst_mid_outputs", 64'(all_outs), 64'd0);
    @(posedge clk);
    #1 chk("rst_hold_idle", 64'(dispatch_active), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    load(16'hFFFE, 16'h0150, 5'h04, 5'h04, 1'b1);
    wr_q.push_back('{addr: 16'hFFFD, data: 8'h01});
    wr_q.push_back('{addr: 16'hFFFC, data: 8'h50});
    jmp_q.push_back('{vec: 8'h50, mask: 5'b00100});
    run_dispatch("post_rst", 1'b1);
    chk("post_rst_pc", 64'(pc_m), 64'h0050);
    chk("post_rst_sp", 64'(sp_m), 64'hFFFC);

    repeat (2) @(negedge clk);
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk("jmp_q_drained", 64'(jmp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
